// File: rtl/instr_burst_writer.sv
// Accepts bundles of up to MAX_WORDS instruction words and writes them one per cycle into a RAM
// at a running cursor; a registered read port exposes the RAM independently of the writer.
module instr_burst_writer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned MAX_WORDS = 6,
  parameter int unsigned WRAP      = 0,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAX_WORDS*DATA_W-1:0] in_words,
  input  logic [CNT_W-1:0]            in_count,
  input  logic                        clear,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [ADDR_W-1:0]           cursor,
  output logic [ADDR_W:0]             fill_level,
  output logic                        full,
  output logic                        wr_done,
  output logic                        err_count,
  output logic                        err_overflow
);

  localparam int unsigned FILL_W = ADDR_W + 1;

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_hold [MAX_WORDS];
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_cursor;
  logic [FILL_W-1:0]   r_fill;
  logic                r_wr_done;
  logic                r_err_count;
  logic                r_err_overflow;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_accept;
  logic                w_cnt_bad;
  logic                w_no_space;
  logic                w_start;
  logic                w_we;
  logic                w_last;
  logic [ADDR_W-1:0]   w_cursor_inc;
  logic [FILL_W-1:0]   w_fill_inc;

  assign in_ready   = (r_state == StIdle) && !clear;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_bad  = in_count > CNT_W'(MAX_WORDS);
  // Space is judged against the whole bundle so an overflowing one is never partially written.
  assign w_no_space = (WRAP == 0) && ((32'(r_fill) + 32'(in_count)) > DEPTH);
  assign w_start    = w_accept && (in_count != '0) && !w_cnt_bad && !w_no_space;
  assign w_we       = (r_state == StWrite) && !clear;
  assign w_last     = r_idx == (r_count - 1'b1);

  assign w_cursor_inc = (r_cursor == ADDR_W'(DEPTH - 1)) ? '0 : r_cursor + 1'b1;
  assign w_fill_inc   = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_nxt = StWrite;
      StWrite: if (w_last) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (clear) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_count        <= '0;
      r_idx          <= '0;
      r_cursor       <= '0;
      r_fill         <= '0;
      r_wr_done      <= 1'b0;
      r_err_count    <= 1'b0;
      r_err_overflow <= 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) r_hold[k] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_done <= 1'b0;
      if (clear) begin
        r_cursor       <= '0;
        r_fill         <= '0;
        r_err_count    <= 1'b0;
        r_err_overflow <= 1'b0;
      end else begin
        if (w_accept) begin
          for (int k = 0; k < MAX_WORDS; k++) r_hold[k] <= in_words[k*DATA_W +: DATA_W];
          r_count <= in_count;
          r_idx   <= '0;
          if (w_cnt_bad) begin
            r_err_count <= 1'b1;
          end else if ((in_count != '0) && w_no_space) begin
            r_err_overflow <= 1'b1;
          end
        end
        if (w_we) begin
          r_cursor <= w_cursor_inc;
          r_fill   <= w_fill_inc;
          r_idx    <= r_idx + 1'b1;
          if (w_last) r_wr_done <= 1'b1;
        end
      end
    end
  end

  // RAM contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_cursor] <= r_hold[r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data      = r_rd_data;
  assign cursor       = r_cursor;
  assign fill_level   = r_fill;
  assign full         = r_fill == FILL_W'(DEPTH);
  assign wr_done      = r_wr_done;
  assign err_count    = r_err_count;
  assign err_overflow = r_err_overflow;

endmodule

// File: doc/instr_burst_writer.md
INSTR_BURST_WRITER -- requirements
Module: instr_burst_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, RAM depth in words; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter MAX_WORDS, default 6, maximum words per bundle; CNT_W = clog2(MAX_WORDS+1).
REQ-004 SHALL have parameter WRAP, default 0; 0 = reject overflowing bundles, 1 = cursor wraps modulo DEPTH.
REQ-005 SHALL have a single clock and an asynchronous, active-high reset, ports as below.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  1  bundle offered.
REQ-009 in_ready  output  1  block can accept a bundle this cycle.
REQ-010 in_words  input  MAX_WORDS*DATA_W  bundle; word k in bits [k*DATA_W +: DATA_W].
REQ-011 in_count  input  CNT_W  number of valid words in bundle.
REQ-012 clear  input  1  synchronous clear of cursor, fill level and error flags.
REQ-013 rd_addr  input  ADDR_W  read address.
REQ-014 rd_data  output  DATA_W  registered read data.
REQ-015 cursor  output  ADDR_W  next RAM address to be written.
REQ-016 fill_level  output  ADDR_W+1  words written since reset/clear, saturating at DEPTH.
REQ-017 full  output  1  high when fill_level == DEPTH.
REQ-018 wr_done  output  1  one-cycle pulse after the last word of a bundle is written.
REQ-019 err_count  output  1  sticky: a bundle with in_count > MAX_WORDS was offered.
REQ-020 err_overflow  output  1  sticky: a bundle rejected for lack of space (WRAP=0 only).

Function
REQ-021 SHALL implement a two-state FSM: IDLE, WRITE; in_ready = 1 exactly when state is IDLE and clear is low.
REQ-022 Handshake: bundle accepted on the rising edge where in_valid && in_ready; in_words/in_count captured into a holding register at that edge.
REQ-023 Accepted bundle with 1 <= in_count <= MAX_WORDS and space available SHALL move to WRITE.
REQ-024 In WRITE, one word per cycle: word k written to RAM[cursor] on the (k+1)-th edge after acceptance; cursor and fill_level increment by 1 per word.
REQ-025 After the last word, FSM SHALL return to IDLE; wr_done and in_ready high in the next cycle; next acceptance earliest in_count+1 cycles after the previous acceptance.
REQ-026 in_count == 0: accepted, no write, no state change, no wr_done.
REQ-027 in_count > MAX_WORDS: accepted and discarded, err_count set, no write.
REQ-028 WRAP=0 and fill_level + in_count > DEPTH: bundle discarded whole, err_overflow set, no write; an exactly-fitting bundle is written and full asserts.
REQ-029 WRAP=1: never rejects for space; cursor wraps from DEPTH-1 to 0, overwriting oldest data; fill_level saturates at DEPTH; err_overflow stays 0.
REQ-030 cursor arithmetic SHALL be modulo DEPTH; fill_level SHALL never exceed DEPTH.
REQ-031 clear SHALL take priority over acceptance and writing: on that edge cursor=0, fill_level=0, errors=0, FSM to IDLE, remaining words of an in-progress bundle dropped, no wr_done; RAM contents unchanged.
REQ-032 Read port: rd_data = RAM[rd_addr] registered, 1-cycle latency, independent of FSM; same-address read and write on one edge returns the old word.

Reset
REQ-033 On rst high, asynchronously: state=IDLE, cursor=0, fill_level=0, full=0, wr_done=0, err_count=0, err_overflow=0, rd_data=0, holding register=0.
REQ-034 RAM contents SHALL NOT be reset; rst asserted mid-bundle SHALL abandon remaining words.
REQ-035 in_ready SHALL be 1 in the first cycle after rst deasserts (clear low).

Verification
REQ-036 Bundle count=3 words A,B,C after reset -> RAM[0..2]=A,B,C, cursor=3, fill_level=3, wr_done one pulse 4 cycles after acceptance, in_ready low 3 cycles.
REQ-037 Back-to-back bundles count=6 then count=2, in_valid held high -> second accepted 7 cycles after first, cursor=8, no word lost or duplicated.
REQ-038 WRAP=0, DEPTH=8, fill=6, offer count=3 -> err_overflow=1, cursor=6; then count=2 -> written, full=1.
REQ-039 WRAP=1, DEPTH=8, cursor=6, count=4 W0..W3 -> RAM[6]=W0, RAM[7]=W1, RAM[0]=W2, RAM[1]=W3, cursor=2, fill_level=8.
REQ-040 clear asserted on 2nd write cycle of a count=5 bundle -> only word 0 written, cursor=0, fill_level=0, no wr_done, in_ready=1 next cycle.
REQ-041 count=7 with MAX_WORDS=6 and count=0 -> err_count=1 for count=7 only, RAM and cursor unchanged, in_ready stays high.
